// File: rtl/imm_pkg.sv
// Shared immediate-format constants and helpers for the immediate packer and extender.
package imm_pkg;

    localparam int FIELD_W = 25;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b100;

    // True when v[31:msb] are all equal, i.e. v fits in an (msb+1)-bit signed field.
    function automatic logic upper_eq(input logic [31:0] v, input int msb);
        logic [31:0] t;
        t = $signed(v) >>> msb;
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/imm_pack_enc.sv
// Combinational encoder: scatters a signed immediate into instruction bits [31:7].
module imm_pack_enc
    import imm_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int C_WIDTH = 2,
    parameter int I_WIDTH = 31
) (
    input  logic [C_WIDTH:0] imm_src,
    input  logic [I_WIDTH:0] v,
    input  logic [WIDTH:0]   base,
    output logic [WIDTH:0]   f,
    output logic             err
);

    always_comb begin
        f   = base;
        err = 1'b0;
        case (imm_src)
            IMM_I: begin
                err = !upper_eq(v, 11);
                if (!err) f[24:13] = v[11:0];
            end
            IMM_B: begin
                err = !upper_eq(v, 12) || v[0];
                if (!err) begin
                    f[24]    = v[12];
                    f[23:18] = v[10:5];
                    f[4:1]   = v[4:1];
                    f[0]     = v[11];
                end
            end
            IMM_J: begin
                err = !upper_eq(v, 20) || v[0];
                if (!err) begin
                    f[24]    = v[20];
                    f[23:14] = v[10:1];
                    f[13]    = v[11];
                    f[12:5]  = v[19:12];
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready immediate packer with error flag and saturating error counter.
module imm_pack
    import imm_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int C_WIDTH = 2,
    parameter int I_WIDTH = 31,
    parameter int TAG_W   = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [C_WIDTH:0]   immSrc,
    input  logic [I_WIDTH:0]   imm_val,
    input  logic [WIDTH:0]     base,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     imm_field,
    output logic               err,
    output logic [TAG_W-1:0]   tag_out,
    output logic [CNT_W-1:0]   err_count
);

    logic               s1_valid_q, s1_valid_d;
    logic [C_WIDTH:0]   s1_src_q, s1_src_d;
    logic [I_WIDTH:0]   s1_v_q, s1_v_d;
    logic [WIDTH:0]     s1_base_q, s1_base_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH:0]     imm_field_q, imm_field_d;
    logic               err_q, err_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               s2_ready;
    logic [WIDTH:0]     enc_f;
    logic               enc_err;

    imm_pack_enc #(
        .WIDTH   (WIDTH),
        .C_WIDTH (C_WIDTH),
        .I_WIDTH (I_WIDTH)
    ) u_enc (
        .imm_src (s1_src_q),
        .v       (s1_v_q),
        .base    (s1_base_q),
        .f       (enc_f),
        .err     (enc_err)
    );

    // Ready chains combinationally from out_ready so a full pipe still streams.
    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_src_d    = s1_src_q;
        s1_v_d      = s1_v_q;
        s1_base_d   = s1_base_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        imm_field_d = imm_field_q;
        err_d       = err_q;
        tag_out_d   = tag_out_q;
        err_count_d = err_count_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_src_d  = immSrc;
                s1_v_d    = imm_val;
                s1_base_d = base;
                s1_tag_d  = tag_in;
            end
        end

        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                imm_field_d = enc_f;
                err_d       = enc_err;
                tag_out_d   = s1_tag_q;
            end
        end

        if (out_valid_q && out_ready && err_q && (err_count_q != '1))
            err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_src_q    <= '0;
            s1_v_q      <= '0;
            s1_base_q   <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            imm_field_q <= '0;
            err_q       <= 1'b0;
            tag_out_q   <= '0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_src_q    <= s1_src_d;
            s1_v_q      <= s1_v_d;
            s1_base_q   <= s1_base_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            imm_field_q <= imm_field_d;
            err_q       <= err_d;
            tag_out_q   <= tag_out_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign imm_field = imm_field_q;
    assign err       = err_q;
    assign tag_out   = tag_out_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed plan steps plus a randomized stream vs a bit-map model.
module tb_imm_pack;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  immSrc;
    logic [31:0] imm_val;
    logic [24:0] base;
    logic [5:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] imm_field;
    logic        err;
    logic [5:0]  tag_out;
    logic [15:0] err_count;

    imm_pack dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .immSrc    (immSrc),
        .imm_val   (imm_val),
        .base      (base),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_field (imm_field),
        .err       (err),
        .tag_out   (tag_out),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] f;
        logic        e;
        logic [5:0]  tag;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          nout = 0;
    bit          lat_chk = 0;
    bit          last_fire_in;
    logic [15:0] cnt = 0;
    logic [24:0] last_f;
    logic        last_err;
    logic [5:0]  last_tag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which immediate bit lands in field bit fi for a format (-1: base bit kept).
    function automatic int bit_src(input logic [2:0] s, input int fi);
        case (s)
            3'b000: return (fi >= 13) ? fi - 13 : -1;
            3'b010: begin
                if (fi == 24) return 12;
                if (fi >= 18 && fi <= 23) return fi - 13;
                if (fi >= 1 && fi <= 4) return fi;
                if (fi == 0) return 11;
                return -1;
            end
            3'b100: begin
                if (fi == 24) return 20;
                if (fi >= 14 && fi <= 23) return fi - 13;
                if (fi == 13) return 11;
                if (fi >= 5 && fi <= 12) return fi + 7;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic void model(input logic [2:0] s, input logic [31:0] v, input logic [24:0] b,
                                  output logic [24:0] f, output logic e);
        longint sv;
        int idx;
        sv = longint'($signed(v));
        case (s)
            3'b000:  e = (sv < -2048) || (sv > 2047);
            3'b010:  e = (sv < -4096) || (sv > 4095) || v[0];
            3'b100:  e = (sv < -(64'sd1 << 20)) || (sv > (64'sd1 << 20) - 1) || v[0];
            default: e = 1'b1;
        endcase
        f = b;
        if (!e) begin
            for (int fi = 0; fi < 25; fi++) begin
                idx = bit_src(s, fi);
                if (idx >= 0) f[fi] = v[idx];
            end
        end
    endfunction

    // Immediate extender: gathers the bits back and sign-extends from the format's top bit.
    function automatic logic [31:0] ext(input logic [2:0] s, input logic [24:0] f);
        logic [31:0] r;
        int idx;
        int top;
        r = '0;
        top = (s == 3'b000) ? 11 : (s == 3'b010) ? 12 : 20;
        for (int fi = 0; fi < 25; fi++) begin
            idx = bit_src(s, fi);
            if (idx >= 0) r[idx] = f[fi];
        end
        for (int i = 0; i < 32; i++)
            if (i > top) r[i] = r[top];
        return r;
    endfunction

    // One clock: check handoff and readiness at the falling edge, then settle past the rising edge.
    task automatic tick();
        exp_t e;
        logic [24:0] mf;
        logic me;
        @(negedge clk);
        chk("in_ready", in_ready, (q.size() < 2) || out_ready);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else begin
                e = q[0];
                chk("imm_field", imm_field, e.f);
                chk("err", err, e.e);
                chk("tag_out", tag_out, e.tag);
                if (out_ready) begin
                    if (lat_chk) chk("latency", cyc - e.acc, 2);
                    void'(q.pop_front());
                    nout++;
                    last_f = imm_field;
                    last_err = err;
                    last_tag = tag_out;
                    if (e.e && cnt != 16'hFFFF) cnt++;
                end
            end
        end
        last_fire_in = in_valid && in_ready;
        if (last_fire_in) begin
            model(immSrc, imm_val, base, mf, me);
            e.f = mf; e.e = me; e.tag = tag_in; e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("err_count", err_count, cnt);
    endtask

    task automatic send1(input logic [2:0] s, input logic [31:0] v, input logic [24:0] b,
                         input logic [5:0] t, input logic [24:0] exp_f, input logic exp_e, input string nm);
        int n0;
        n0 = nout;
        lat_chk = 1;
        out_ready = 1; in_valid = 1; immSrc = s; imm_val = v; base = b; tag_in = t;
        tick();
        in_valid = 0;
        tick();
        tick();
        lat_chk = 0;
        chk({nm, "_handoff"}, nout - n0, 1);
        chk({nm, "_f"}, last_f, exp_f);
        chk({nm, "_err"}, last_err, exp_e);
        chk({nm, "_tag"}, last_tag, t);
    endtask

    initial begin
        int acc;
        int n0;
        int k;
        reset_n = 0; in_valid = 0; out_ready = 0;
        immSrc = 0; imm_val = 0; base = 0; tag_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_imm_field", imm_field, 25'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_tag_out", tag_out, 6'd0);
        chk("rst_err_count", err_count, 16'd0);
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        send1(3'b000, 32'hFFFFF800, 25'd0, 6'd5, 25'h1000000, 1'b0, "i_min");
        send1(3'b000, 32'h00000800, 25'h0000ABC, 6'd6, 25'h0000ABC, 1'b1, "i_range");
        chk("err_count_one", err_count, 16'd1);
        send1(3'b010, 32'hFFFFF000, 25'd0, 6'd7, 25'h1000000, 1'b0, "b_min");
        send1(3'b010, 32'h00000003, 25'h0123456, 6'd8, 25'h0123456, 1'b1, "b_misalign");
        send1(3'b100, 32'h000FFFFE, 25'd0, 6'd9, 25'h0FFFFE0, 1'b0, "j_max");
        chk("j_roundtrip", ext(3'b100, last_f), 32'h000FFFFE);

        // Backpressure: consumer stalled while the producer keeps offering tags 1..3.
        out_ready = 0; in_valid = 1; immSrc = 3'b000; imm_val = 32'd100; base = 25'h155; tag_in = 6'd1;
        acc = 0;
        repeat (4) begin
            tick();
            if (last_fire_in) begin acc++; tag_in = tag_in + 1'b1; imm_val = imm_val + 32'd1; end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        out_ready = 1;
        n0 = nout;
        k = 0;
        while (k < 3) begin
            tick();
            if (last_fire_in) in_valid = 0;
            k++;
        end
        chk("bp_back_to_back", nout - n0, 3);
        chk("bp_last_tag", last_tag, 6'd3);
        chk("bp_drained", q.size(), 0);

        // Randomized stream with random producer/consumer stalls.
        for (int i = 0; i < 600; i++) begin
            int mode;
            int sel;
            mode = $urandom_range(0, 3);
            sel = $urandom_range(0, 7);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            immSrc = (sel < 2) ? 3'b000 : (sel < 4) ? 3'b010 : (sel < 6) ? 3'b100 : 3'($urandom);
            case (mode)
                0: imm_val = $urandom;
                1: imm_val = 32'($signed($urandom_range(0, 16383)) - 8192);
                2: imm_val = 32'($signed($urandom_range(0, 4194303)) - 2097152);
                default: imm_val = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFFFFFE;
            endcase
            base = 25'($urandom);
            tag_in = 6'($urandom);
            tick();
        end
        in_valid = 0; out_ready = 1;
        k = 0;
        while (q.size() != 0 && k < 20) begin tick(); k++; end
        chk("rand_drained", q.size(), 0);

        // Reset with both stages full.
        out_ready = 0; in_valid = 1; immSrc = 3'b111; imm_val = 32'd1; base = 25'h1; tag_in = 6'd33;
        tick();
        tick();
        chk("mid_full", q.size(), 2);
        reset_n = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_err_count", err_count, 16'd0);
        q.delete();
        cnt = 0;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1;
        out_ready = 1;
        repeat (3) begin
            tick();
            chk("post_rst_no_out", out_valid, 1'b0);
        end

        send1(3'b001, 32'd4, 25'h0ABCDEF, 6'd40, 25'h0ABCDEF, 1'b1, "unsupported");
        chk("unsupported_count", err_count, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
